// File: rtl/pc_fetch_pkg.sv
// Shared fetch/decode definitions: widths, reset PC, opcode constants,
// instruction field slices and the fetch FSM state encoding.
package pc_fetch_pkg;

    localparam int PC_W  = 9;
    localparam int OP_W  = 23;
    localparam int CNT_W = 16;

    localparam logic [PC_W-1:0] RESET_PC = 9'd0;

    localparam logic [4:0] OPC_LI   = 5'h01;
    localparam logic [4:0] OPC_JMP  = 5'h02;
    localparam logic [4:0] OPC_JNZ  = 5'h03;
    localparam logic [4:0] OPC_ZNJ  = 5'h04;
    localparam logic [4:0] HALT_OPC = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    function automatic logic [4:0] opc_of(input logic [OP_W-1:0] op);
        return op[22:18];
    endfunction

    function automatic logic [5:0] dst_of(input logic [OP_W-1:0] op);
        return op[17:12];
    endfunction

    function automatic logic [5:0] src1_of(input logic [OP_W-1:0] op);
        return op[11:6];
    endfunction

    function automatic logic [5:0] src0_of(input logic [OP_W-1:0] op);
        return op[5:0];
    endfunction

    function automatic logic [4:0] imm_of(input logic [OP_W-1:0] op);
        return op[4:0];
    endfunction

    function automatic logic [PC_W-1:0] tgt_of(input logic [OP_W-1:0] op);
        return op[8:0];
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, reads the synchronous ROM and
// presents one opcode per 3-cycle FETCH/LOAD/EXEC slot; stops on HALT.
//   clk, rst_n          : clock, async active-low reset
//   run, restart        : run level, restart-from-HALT pulse
//   imem_en/addr/data   : ROM port (data valid the cycle after en)
//   pc_in, pc_we        : jump target / taken from decoder (EXEC only)
//   op, op_valid        : opcode to decoder, valid in EXEC
//   pc, halted, icount  : current PC, HALT flag, retired count (saturating)
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    output logic             imem_en,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [OP_W-1:0]  imem_data,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             pc_we,
    output logic [OP_W-1:0]  op,
    output logic             op_valid,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            op_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        icount_d = icount_q;
        imem_en  = 1'b0;
        op_valid = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_en = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                op_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                op_valid = 1'b1;
                if (opc_of(op_q) == HALT_OPC) begin
                    // HALT retires nothing and leaves the PC on itself
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_we ? pc_in : pc_q + PC_W'(1);
                    if (icount_q != '1) icount_d = icount_q + CNT_W'(1);
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (restart) begin
                    pc_d    = RESET_PC;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign op        = op_q;
    assign icount    = icount_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a ROM model and a minimal decoder
// model (only JMP drives pc_we; JNZ behaves as not-taken).
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             restart;
    logic             imem_en;
    logic [PC_W-1:0]  imem_addr;
    logic [OP_W-1:0]  imem_data;
    logic [PC_W-1:0]  pc_in;
    logic             pc_we;
    logic [OP_W-1:0]  op;
    logic             op_valid;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] icount;

    logic [OP_W-1:0] rom [512];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (imem_en) imem_data <= rom[imem_addr];

    // decoder model: not gated with op_valid, so stale JMPs must be ignored
    assign pc_we = (op[22:18] == OPC_JMP);
    assign pc_in = op[8:0];

    pc_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .restart   (restart),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .pc_in     (pc_in),
        .pc_we     (pc_we),
        .op        (op),
        .op_valid  (op_valid),
        .pc        (pc),
        .halted    (halted),
        .icount    (icount)
    );

    localparam logic [OP_W-1:0] I_JMP100 = {OPC_JMP, 9'd0, 9'd100};
    localparam logic [OP_W-1:0] I_JMP511 = {OPC_JMP, 9'd0, 9'd511};
    localparam logic [OP_W-1:0] I_JNZ    = {OPC_JNZ, 18'd0};
    localparam logic [OP_W-1:0] I_HALT   = {HALT_OPC, 18'd0};

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        run = 1'b0;
        restart = 1'b0;
        step(2);
        n_cmp++;
        if (pc !== 9'd0) begin
            n_err++;
            $display("FAIL rst_pc got %0d want 0", pc);
        end
        n_cmp++;
        if (op !== '0) begin
            n_err++;
            $display("FAIL rst_op got %h want 0", op);
        end
        n_cmp++;
        if ({imem_en, op_valid, halted} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_flags got %b want 000",
                     {imem_en, op_valid, halted});
        end
        n_cmp++;
        if (icount !== 16'd0) begin
            n_err++;
            $display("FAIL rst_icount got %0d want 0", icount);
        end
        rst_n = 1'b1;
        step(2);
        n_cmp++;
        if (imem_en !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_run got %b want 0", imem_en);
        end
        run = 1'b1;
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (imem_en !== 1'b1 || imem_addr !== 9'(i) ||
                op_valid !== 1'b0) begin
                n_err++;
                $display("FAIL seq_fetch%0d got en=%b a=%0d v=%b want 1 %0d 0",
                         i, imem_en, imem_addr, op_valid, i);
            end
            step();
            n_cmp++;
            if (imem_en !== 1'b0 || op_valid !== 1'b0) begin
                n_err++;
                $display("FAIL seq_load%0d got en=%b v=%b want 0 0",
                         i, imem_en, op_valid);
            end
            step();
            n_cmp++;
            if (op_valid !== 1'b1 || op !== rom[i]) begin
                n_err++;
                $display("FAIL seq_exec%0d got v=%b op=%h want 1 %h",
                         i, op_valid, op, rom[i]);
            end
        end
        step();
        n_cmp++;
        if (icount !== 16'd3 || imem_addr !== 9'd3) begin
            n_err++;
            $display("FAIL seq_count got cnt=%0d a=%0d want 3 3",
                     icount, imem_addr);
        end
    endtask

    task automatic test_jump;
        step(3);
        n_cmp++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd4) begin
            n_err++;
            $display("FAIL jmp_fetch4 got en=%b a=%0d want 1 4",
                     imem_en, imem_addr);
        end
        step(2);
        n_cmp++;
        if (op_valid !== 1'b1 || op !== I_JMP100) begin
            n_err++;
            $display("FAIL jmp_exec got v=%b op=%h want 1 %h",
                     op_valid, op, I_JMP100);
        end
        step();
        n_cmp++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd100 ||
            icount !== 16'd5) begin
            n_err++;
            $display("FAIL jmp_target got en=%b a=%0d c=%0d want 1 100 5",
                     imem_en, imem_addr, icount);
        end
    endtask

    task automatic test_wrap;
        step(3);
        n_cmp++;
        if (imem_addr !== 9'd101) begin
            n_err++;
            $display("FAIL wrap_seq got %0d want 101", imem_addr);
        end
        step(3);
        n_cmp++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd511 ||
            icount !== 16'd7) begin
            n_err++;
            $display("FAIL wrap_511 got en=%b a=%0d c=%0d want 1 511 7",
                     imem_en, imem_addr, icount);
        end
        step(3);
        n_cmp++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd0 || pc !== 9'd0 ||
            icount !== 16'd8) begin
            n_err++;
            $display("FAIL wrap_0 got en=%b a=%0d c=%0d want 1 0 8",
                     imem_en, imem_addr, icount);
        end
    endtask

    task automatic test_halt;
        bit found = 1'b0;
        bit bad = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (op_valid === 1'b1 && pc === 9'd7) found = 1'b1;
        end
        n_cmp++;
        if (!found || op !== I_HALT) begin
            n_err++;
            $display("FAIL halt_reach got found=%b op=%h want 1 %h",
                     found, op, I_HALT);
        end
        step();
        n_cmp++;
        if (halted !== 1'b1 || pc !== 9'd7 || icount !== 16'd15) begin
            n_err++;
            $display("FAIL halt_enter got h=%b pc=%0d c=%0d want 1 7 15",
                     halted, pc, icount);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_en !== 1'b0 || halted !== 1'b1 ||
                op_valid !== 1'b0 || pc !== 9'd7) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL halt_hold got activity want idle in HALT");
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_cmp++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd0 ||
            halted !== 1'b0 || pc !== 9'd0) begin
            n_err++;
            $display("FAIL halt_restart got en=%b a=%0d h=%b want 1 0 0",
                     imem_en, imem_addr, halted);
        end
    endtask

    task automatic test_async_reset;
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (imem_en === 1'b1 && imem_addr === 9'd5) found = 1'b1;
        end
        step();
        n_cmp++;
        if (!found || op === '0) begin
            n_err++;
            $display("FAIL arst_setup got found=%b op=%h want 1 nonzero",
                     found, op);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (op !== '0 || pc !== 9'd0 || op_valid !== 1'b0 ||
            imem_en !== 1'b0 || icount !== 16'd0) begin
            n_err++;
            $display("FAIL arst_now got op=%h pc=%0d v=%b c=%0d want 0 0 0 0",
                     op, pc, op_valid, icount);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_run_drop;
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (imem_en === 1'b1 && imem_addr === 9'd3) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL drop_reach got no fetch of 3 want fetch 3");
        end
        run = 1'b0;
        force dut.icount_q = 16'hFFFF;
        step();
        release dut.icount_q;
        step();
        n_cmp++;
        if (op_valid !== 1'b1) begin
            n_err++;
            $display("FAIL drop_exec got v=%b want 1", op_valid);
        end
        step();
        n_cmp++;
        if (imem_en !== 1'b0 || op_valid !== 1'b0 || pc !== 9'd4 ||
            icount !== 16'hFFFF) begin
            n_err++;
            $display("FAIL drop_idle got en=%b pc=%0d c=%h want 0 4 ffff",
                     imem_en, pc, icount);
        end
        step();
        n_cmp++;
        if (imem_en !== 1'b0) begin
            n_err++;
            $display("FAIL drop_stay got en=%b want 0", imem_en);
        end
        run = 1'b1;
        step();
        n_cmp++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd4) begin
            n_err++;
            $display("FAIL drop_resume got en=%b a=%0d want 1 4",
                     imem_en, imem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = {OPC_LI, 18'(i + 1)};
        rom[4]   = I_JMP100;
        rom[101] = I_JMP511;
        rom[511] = I_JNZ;
        test_reset();
        test_sequential();
        test_jump();
        test_wrap();
        rom[4] = {OPC_LI, 18'd5};
        rom[7] = I_HALT;
        test_halt();
        test_async_reset();
        test_run_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
